// File: rtl/pong_pkg.sv
// pong_pkg: FSM/direction types, default screen geometry and a centring helper
// shared by the Pong game sequencer and its paddle registers.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        POINT = 2'd2,
        OVER  = 2'd3
    } state_t;

    // NEG is left on the x axis and up on the y axis; POS is right / down.
    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_t;

    localparam int SCREEN_W_DEF  = 640;
    localparam int SCREEN_H_DEF  = 480;
    localparam int PADDLE_W_DEF  = 5;
    localparam int PADDLE_H_DEF  = 50;
    localparam int BALL_SIZE_DEF = 4;

    function automatic logic [9:0] centre(input int span, input int size);
        return 10'((span - size) / 2);
    endfunction

    localparam logic [9:0] BALL_X_MID   = centre(SCREEN_W_DEF, BALL_SIZE_DEF);
    localparam logic [9:0] BALL_Y_MID   = centre(SCREEN_H_DEF, BALL_SIZE_DEF);
    localparam logic [9:0] PADDLE_Y_MID = centre(SCREEN_H_DEF, PADDLE_H_DEF);

endpackage

// File: rtl/pong_paddle_ctrl.sv
// pong_paddle_ctrl: saturating paddle top-edge register; moves one step on an enabled
// frame, recentres on request, result visible the cycle after the enabling pulse.
module pong_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int PADDLE_H    = PADDLE_H_DEF,
    parameter int PADDLE_STEP = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       recentre_i,
    input  logic       up_i,
    input  logic       dn_i,
    output logic [8:0] y_o
);

    localparam logic [8:0] Y_MAX = 9'(SCREEN_H - PADDLE_H);
    localparam logic [8:0] Y_MID = 9'(centre(SCREEN_H, PADDLE_H));
    localparam logic [8:0] STEP  = 9'(PADDLE_STEP);

    logic [8:0] y_q, y_d;

    // Limits are compared before stepping so the register never wraps.
    always_comb begin
        y_d = y_q;
        if (recentre_i) begin
            y_d = Y_MID;
        end else if (en_i && up_i && !dn_i) begin
            y_d = (y_q < STEP) ? '0 : y_q - STEP;
        end else if (en_i && dn_i && !up_i) begin
            y_d = (y_q > Y_MAX - STEP) ? Y_MAX : y_q + STEP;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_q <= Y_MID;
        end else begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate Pong sequencer; all state updates the cycle after frame_tick, no backpressure.
// Build option PONG_SPIN_EN: hits on the outer quarters of a paddle double the vertical ball speed.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int PADDLE_W     = PADDLE_W_DEF,
    parameter int PADDLE_H     = PADDLE_H_DEF,
    parameter int BALL_SIZE    = BALL_SIZE_DEF,
    parameter int PADDLE_STEP  = 2,
    parameter int BALL_STEP    = 1,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_MAX    = 9
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_visible,
    output logic [8:0] p1_y,
    output logic [8:0] p2_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over,
    output logic [1:0] state
);

    localparam logic [9:0]    BALL_X0  = centre(SCREEN_W, BALL_SIZE);
    localparam logic [9:0]    BALL_Y0  = centre(SCREEN_H, BALL_SIZE);
    localparam logic [9:0]    BSZ      = 10'(BALL_SIZE);
    localparam logic [9:0]    BSTEP    = 10'(BALL_STEP);
    localparam logic [9:0]    PH       = 10'(PADDLE_H);
    localparam logic [9:0]    SH       = 10'(SCREEN_H);
    localparam logic [9:0]    Y_BOT    = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]    X_HIT_L  = 10'(PADDLE_W);
    localparam logic [9:0]    X_HIT_R  = 10'(SCREEN_W - PADDLE_W - BALL_SIZE);
    localparam logic [9:0]    X_EDGE_L = 10'(PADDLE_W + BALL_STEP);
    localparam logic [9:0]    X_EDGE_R = 10'(SCREEN_W - PADDLE_W - BALL_SIZE - BALL_STEP);
    localparam int            CW       = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SERVE_FRAMES);
    localparam logic [3:0]    SCORE_END = 4'(SCORE_MAX);

    state_t        state_q;
    logic [9:0]    ball_x_q, ball_y_q;
    logic          vis_q, over_q, p2_scored_q;
    logic [3:0]    score_p1_q, score_p2_q, score_d;
    logic [CW-1:0] cnt_q;
    dir_t          dx_q, dy_q;

    logic          any_btn, pad_en, pad_recentre, overlap;
    logic [9:0]    pad_y, dy_mag;
    logic [9:0]    play_x_d, play_y_d;
    dir_t          play_dx_d, play_dy_d;
    logic          play_miss;

    assign any_btn      = p1_up | p1_dn | p2_up | p2_dn;
    assign pad_en       = frame_tick && (state_q == SERVE || state_q == PLAY);
    assign pad_recentre = frame_tick && state_q == OVER && any_btn;

    pong_paddle_ctrl #(.SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)) u_pad1 (
        .clk_i(pixel_clk), .rst_i(reset), .en_i(pad_en), .recentre_i(pad_recentre),
        .up_i(p1_up), .dn_i(p1_dn), .y_o(p1_y)
    );

    pong_paddle_ctrl #(.SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)) u_pad2 (
        .clk_i(pixel_clk), .rst_i(reset), .en_i(pad_en), .recentre_i(pad_recentre),
        .up_i(p2_up), .dn_i(p2_dn), .y_o(p2_y)
    );

    // The paddle the ball is heading towards, at its pre-tick position.
    assign pad_y   = (dx_q == DIR_NEG) ? {1'b0, p1_y} : {1'b0, p2_y};
    assign overlap = (ball_y_q + BSZ > pad_y) && (ball_y_q < pad_y + PH);
    assign score_d = (p2_scored_q ? score_p2_q : score_p1_q) + 4'd1;

`ifdef PONG_SPIN_EN
    logic [9:0] dy_mag_q, spin_mag, ctr_row;
    assign ctr_row  = ball_y_q + 10'(BALL_SIZE / 2);
    assign spin_mag = (ctr_row < pad_y + 10'(PADDLE_H / 4) ||
                       ctr_row >= pad_y + PH - 10'(PADDLE_H / 4)) ? 10'(2 * BALL_STEP) : BSTEP;
    assign dy_mag   = dy_mag_q;
`else
    assign dy_mag   = BSTEP;
`endif

    always_comb begin
        play_x_d  = ball_x_q;
        play_y_d  = ball_y_q;
        play_dx_d = dx_q;
        play_dy_d = dy_q;
        play_miss = 1'b0;
        if (dy_q == DIR_NEG) begin
            if (ball_y_q < dy_mag) begin
                play_y_d  = '0;
                play_dy_d = DIR_POS;
            end else begin
                play_y_d  = ball_y_q - dy_mag;
            end
        end else if (ball_y_q + BSZ + dy_mag > SH) begin
            play_y_d  = Y_BOT;
            play_dy_d = DIR_NEG;
        end else begin
            play_y_d  = ball_y_q + dy_mag;
        end
        if (dx_q == DIR_NEG) begin
            if (ball_x_q >= X_EDGE_L) begin
                play_x_d  = ball_x_q - BSTEP;
            end else if (overlap) begin
                play_x_d  = X_HIT_L;
                play_dx_d = DIR_POS;
            end else begin
                play_miss = 1'b1;
            end
        end else begin
            if (ball_x_q <= X_EDGE_R) begin
                play_x_d  = ball_x_q + BSTEP;
            end else if (overlap) begin
                play_x_d  = X_HIT_R;
                play_dx_d = DIR_NEG;
            end else begin
                play_miss = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q     <= SERVE;
            ball_x_q    <= BALL_X0;
            ball_y_q    <= BALL_Y0;
            vis_q       <= 1'b1;
            over_q      <= 1'b0;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            cnt_q       <= CNT_LOAD;
            dx_q        <= DIR_NEG;
            dy_q        <= DIR_POS;
            p2_scored_q <= 1'b0;
`ifdef PONG_SPIN_EN
            dy_mag_q    <= BSTEP;
`endif
        end else if (frame_tick) begin
            case (state_q)
                SERVE: begin
                    if (cnt_q <= CW'(1)) begin
                        cnt_q   <= '0;
                        state_q <= PLAY;
                    end else begin
                        cnt_q   <= cnt_q - CW'(1);
                    end
                end
                PLAY: begin
                    ball_x_q <= play_x_d;
                    ball_y_q <= play_y_d;
                    dx_q     <= play_dx_d;
                    dy_q     <= play_dy_d;
                    if (play_miss) begin
                        state_q     <= POINT;
                        vis_q       <= 1'b0;
                        p2_scored_q <= (dx_q == DIR_NEG);
                    end
`ifdef PONG_SPIN_EN
                    if (play_dx_d != dx_q) dy_mag_q <= spin_mag;
`endif
                end
                POINT: begin
                    if (p2_scored_q) score_p2_q <= score_d;
                    else             score_p1_q <= score_d;
                    if (score_d == SCORE_END) begin
                        state_q <= OVER;
                        over_q  <= 1'b1;
                    end else begin
                        state_q  <= SERVE;
                        vis_q    <= 1'b1;
                        ball_x_q <= BALL_X0;
                        ball_y_q <= BALL_Y0;
                        cnt_q    <= CNT_LOAD;
                        // Serve towards the player who just conceded.
                        dx_q     <= p2_scored_q ? DIR_NEG : DIR_POS;
`ifdef PONG_SPIN_EN
                        dy_mag_q <= BSTEP;
`endif
                    end
                end
                OVER: begin
                    if (any_btn) begin
                        state_q    <= SERVE;
                        over_q     <= 1'b0;
                        vis_q      <= 1'b1;
                        score_p1_q <= '0;
                        score_p2_q <= '0;
                        ball_x_q   <= BALL_X0;
                        ball_y_q   <= BALL_Y0;
                        cnt_q      <= CNT_LOAD;
                        dx_q       <= DIR_NEG;
                        dy_q       <= DIR_POS;
`ifdef PONG_SPIN_EN
                        dy_mag_q   <= BSTEP;
`endif
                    end
                end
                default: state_q <= SERVE;
            endcase
        end
    end

    assign ball_x       = ball_x_q;
    assign ball_y       = ball_y_q;
    assign ball_visible = vis_q;
    assign score_p1     = score_p1_q;
    assign score_p2     = score_p2_q;
    assign game_over    = over_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed frame sequence with hand-computed checkpoints queued per observation;
// a monitor compares after every frame_tick and immediately after every reset assertion.
module tb_pong_game_ctrl;

    logic       pixel_clk  = 1'b0;
    logic       reset      = 1'b0;
    logic       frame_tick = 1'b0;
    logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
    logic [9:0] ball_x, ball_y;
    logic       ball_visible, game_over;
    logic [8:0] p1_y, p2_y;
    logic [3:0] score_p1, score_p2;
    logic [1:0] state;

    pong_game_ctrl dut (
        .pixel_clk(pixel_clk), .reset(reset), .frame_tick(frame_tick),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .ball_x(ball_x), .ball_y(ball_y), .ball_visible(ball_visible),
        .p1_y(p1_y), .p2_y(p2_y), .score_p1(score_p1), .score_p2(score_p2),
        .game_over(game_over), .state(state)
    );

    always #5 pixel_clk = ~pixel_clk;

    localparam int F_BX = 0, F_BY = 1, F_VIS = 2, F_P1 = 3, F_P2 = 4,
                   F_S1 = 5, F_S2 = 6, F_GO = 7, F_ST = 8;

    typedef struct {
        int obs;
        int fld;
        int val;
    } exp_t;

    exp_t sb[$];
    int   drv_obs = 0;
    int   mon_obs = 0;
    int   total   = 0;
    int   bad     = 0;

    function automatic int actual(input int f);
        case (f)
            F_BX:    return int'(ball_x);
            F_BY:    return int'(ball_y);
            F_VIS:   return int'(ball_visible);
            F_P1:    return int'(p1_y);
            F_P2:    return int'(p2_y);
            F_S1:    return int'(score_p1);
            F_S2:    return int'(score_p2);
            F_GO:    return int'(game_over);
            F_ST:    return int'(state);
            default: return -1;
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            F_BX:    return "ball_x";
            F_BY:    return "ball_y";
            F_VIS:   return "ball_visible";
            F_P1:    return "p1_y";
            F_P2:    return "p2_y";
            F_S1:    return "score_p1";
            F_S2:    return "score_p2";
            F_GO:    return "game_over";
            F_ST:    return "state";
            default: return "unknown";
        endcase
    endfunction

    task automatic ex(input int f, input int v);
        exp_t e;
        e.obs = drv_obs;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic ex_reset();
        ex(F_BX, 318); ex(F_BY, 238); ex(F_VIS, 1); ex(F_P1, 215); ex(F_P2, 215);
        ex(F_S1, 0);   ex(F_S2, 0);   ex(F_GO, 0);  ex(F_ST, 0);
    endtask

    task automatic observe();
        while (sb.size() > 0 && sb[0].obs <= mon_obs) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (e.obs < mon_obs) begin
                bad++;
                $display("FAIL obs%0d %s never observed, expected %0d", e.obs, fname(e.fld), e.val);
            end else if (actual(e.fld) != e.val) begin
                bad++;
                $display("FAIL obs%0d %s got %0d expected %0d", e.obs, fname(e.fld), actual(e.fld), e.val);
            end
        end
        mon_obs++;
    endtask

    // Monitor: the DUT presents new outputs one cycle after each frame_tick.
    initial forever begin
        @(posedge pixel_clk);
        if (frame_tick) begin
            @(negedge pixel_clk);
            observe();
        end
    end

    // Reset must act without any clock edge: sample 1 ns after it rises, mid-cycle.
    initial forever begin
        @(posedge reset);
        #1;
        observe();
    end

    task automatic tick(input logic u1, input logic d1, input logic u2, input logic d2);
        @(negedge pixel_clk);
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
        frame_tick = 1'b1;
        @(negedge pixel_clk);
        frame_tick = 1'b0;
        p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
        drv_obs++;
    endtask

    task automatic pulse_reset();
        @(negedge pixel_clk);
        #2 reset = 1'b1;
        #25;
        @(negedge pixel_clk);
        reset = 1'b0;
        drv_obs++;
    endtask

    initial begin
        logic u1, d1, d2;

        ex_reset();
        pulse_reset();

        for (int t = 1; t <= 4440; t++) begin
            u1 = (t <= 120);
            d1 = (t == 10) || (t >= 121 && t <= 310);
            d2 = (t <= 120) || (t == 4004);
            case (t)
                1:    begin ex(F_BX, 318); ex(F_BY, 238); ex(F_ST, 0); ex(F_VIS, 1);
                            ex(F_P1, 213); ex(F_P2, 217); end
                9:    ex(F_P1, 197);
                10:   ex(F_P1, 197);
                11:   ex(F_P1, 195);
                59:   begin ex(F_ST, 0); ex(F_BX, 318); end
                60:   begin ex(F_ST, 1); ex(F_BX, 318); ex(F_BY, 238); end
                61:   begin ex(F_BX, 317); ex(F_BY, 239); end
                107:  ex(F_P2, 429);
                108:  begin ex(F_P1, 1); ex(F_P2, 430); end
                109:  begin ex(F_P1, 0); ex(F_P2, 430); end
                120:  ex(F_P1, 0);
                298:  begin ex(F_BY, 476); ex(F_BX, 80); end
                299:  begin ex(F_BY, 476); ex(F_BX, 79); end
                300:  begin ex(F_BY, 475); ex(F_BX, 78); end
                310:  ex(F_P1, 380);
                374:  begin ex(F_BX, 5); ex(F_BY, 401); ex(F_ST, 1); end
                375:  begin ex(F_BX, 6); ex(F_BY, 400); end
                775:  begin ex(F_BY, 0); ex(F_BX, 406); end
                776:  ex(F_BY, 0);
                777:  begin ex(F_BY, 1); ex(F_BX, 408); end
                1000: begin ex(F_BX, 631); ex(F_BY, 224); end
                1001: begin ex(F_VIS, 0); ex(F_S1, 0); end
                1002: begin ex(F_S2, 0); ex(F_VIS, 1); ex(F_BX, 318); ex(F_BY, 238); end
                1062: ex(F_ST, 1);
                1063: begin ex(F_BX, 319); ex(F_BY, 239); end
                4002: begin ex(F_GO, 1); ex(F_VIS, 0); ex(F_P1, 380); ex(F_P2, 430); end
                4003: begin ex(F_ST, 3); ex(F_S1, 9); ex(F_P1, 380); ex(F_GO, 1); end
                4004: begin ex(F_S1, 0); ex(F_S2, 0); ex(F_ST, 0); ex(F_GO, 0); ex(F_VIS, 1);
                            ex(F_P1, 215); ex(F_P2, 215); ex(F_BX, 318); ex(F_BY, 238); end
                4064: ex(F_ST, 1);
                4065: begin ex(F_BX, 317); ex(F_BY, 239); end
                4377: begin ex(F_BX, 5); ex(F_BY, 402); end
                4378: begin ex(F_ST, 2); ex(F_VIS, 0); end
                4379: begin ex(F_S2, 1); ex(F_S1, 0); ex(F_ST, 0); ex(F_BX, 318); ex(F_BY, 238); end
                4439: ex(F_ST, 1);
                4440: begin ex(F_BX, 317); ex(F_BY, 237); end
                default: ;
            endcase
            // P1 misses nothing from here: each point is 375 frames (60 serve, 314 play, 1 point).
            if (t >= 1001 && t <= 4001 && (t - 1001) % 375 == 0) ex(F_ST, 2);
            if (t >= 1002 && t <= 4002 && (t - 1002) % 375 == 0) begin
                ex(F_S1, 1 + (t - 1002) / 375);
                ex(F_ST, (t == 4002) ? 3 : 0);
            end
            tick(u1, d1, 1'b0, d2);
        end

        repeat (3) @(negedge pixel_clk);
        ex_reset();
        pulse_reset();

        ex(F_BX, 318); ex(F_ST, 0); ex(F_P1, 215);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (4) @(negedge pixel_clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL obs%0d %s never observed, expected %0d", e.obs, fname(e.fld), e.val);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
